up_counter_cu: RTL

//  Control unit feeding the up/down counter's i_run/i_clear/i_updown inputs from three raw board buttons.
//  Per-button 2-FF synchronizer, counter debouncer and rising-edge detector.
//  A Moore FSM (STOP/RUN/CLEAR) then turns each press into the counter's run, clear and direction controls.

---
 rtl/up_counter_cu_if.sv | 31 +++
 rtl/up_counter_cu.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/up_counter_cu_if.sv
// Button/control bundle between the board-side stimulus and the counter control unit.
// master drives the raw buttons and observes the counter controls; slave is the control unit.
interface up_counter_cu_if;
   logic       btn_runstop;
   logic       btn_clear;
   logic       btn_mode;
   logic       o_run;
   logic       o_clear;
   logic       o_updown;
   logic [1:0] o_state;

   modport master (
      output btn_runstop,
      output btn_clear,
      output btn_mode,
      input  o_run,
      input  o_clear,
      input  o_updown,
      input  o_state
   );

   modport slave (
      input  btn_runstop,
      input  btn_clear,
      input  btn_mode,
      output o_run,
      output o_clear,
      output o_updown,
      output o_state
   );
endinterface

// File: rtl/up_counter_cu.sv
// Control unit for the up/down counter: three raw pushbuttons are synchronized,
// debounced and edge-detected, then a STOP/RUN/CLEAR Moore FSM turns the presses
// into the counter's run level, one-cycle clear strobe and direction level.
module up_counter_cu #(
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic            clk,
   input  logic            reset,
   up_counter_cu_if.slave  bus
);

   // A counter width of at least one bit keeps the smallest legal DB_CYCLES well formed.
   localparam int               CNT_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   // Bit positions of the three buttons in the per-button vectors.
   localparam int NBTN     = 3;
   localparam int IDX_RUN  = 0;
   localparam int IDX_CLR  = 1;
   localparam int IDX_MODE = 2;

   typedef enum logic [1:0] {
      ST_STOP  = 2'b00,
      ST_RUN   = 2'b01,
      ST_CLEAR = 2'b10
   } state_t;

   logic [NBTN-1:0]  btn_s;
   logic [NBTN-1:0]  sync1_q;
   logic [NBTN-1:0]  sync2_q;
   logic [NBTN-1:0]  stable_q;
   logic [NBTN-1:0]  stable_d;
   logic [NBTN-1:0]  stable_dly_q;
   logic [NBTN-1:0]  press_s;
   logic [CNT_W-1:0] cnt_q [NBTN];
   logic [CNT_W-1:0] cnt_d [NBTN];
   state_t           state_q;
   logic             updown_q;

   assign btn_s = {bus.btn_mode, bus.btn_clear, bus.btn_runstop};

   // Two-flop synchronizer bringing the asynchronous buttons into the clk domain.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 3'b000;
         sync2_q <= 3'b000;
      end else begin
         sync1_q <= btn_s;
         sync2_q <= sync1_q;
      end
   end

   // Debounce next state: a new level is accepted only after it has held for DB_CYCLES
   // consecutive samples; any return to the accepted level restarts the count.
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < NBTN; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync2_q[i] == stable_q[i]) begin
            cnt_d[i] = CNT_ZERO;
         end else if (cnt_q[i] == CNT_LAST) begin
            stable_d[i] = sync2_q[i];
            cnt_d[i]    = CNT_ZERO;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
         end
      end
   end

   // Debounce state registers: per-button hold counter and accepted level.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stable_q <= 3'b000;
         for (int i = 0; i < NBTN; i++) begin
            cnt_q[i] <= CNT_ZERO;
         end
      end else begin
         stable_q <= stable_d;
         for (int i = 0; i < NBTN; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // Delayed copy of the accepted level for rising-edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stable_dly_q <= 3'b000;
      end else begin
         stable_dly_q <= stable_q;
      end
   end

   // One-cycle press event on each debounced 0->1 transition; releases are silent.
   assign press_s = stable_q & ~stable_dly_q;

   // Control FSM plus direction register. Clear has priority over run/stop in STOP,
   // mode only toggles direction while stopped, and CLEAR always lasts one cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_STOP;
         updown_q <= 1'b0;
      end else begin
         case (state_q)
            ST_STOP: begin
               if (press_s[IDX_CLR]) begin
                  state_q <= ST_CLEAR;
               end else if (press_s[IDX_RUN]) begin
                  state_q <= ST_RUN;
               end else begin
                  state_q <= ST_STOP;
               end
               if (press_s[IDX_MODE]) begin
                  updown_q <= ~updown_q;
               end else begin
                  updown_q <= updown_q;
               end
            end
            ST_RUN: begin
               if (press_s[IDX_RUN]) begin
                  state_q <= ST_STOP;
               end else begin
                  state_q <= ST_RUN;
               end
               updown_q <= updown_q;
            end
            ST_CLEAR: begin
               state_q  <= ST_STOP;
               updown_q <= updown_q;
            end
            default: begin
               state_q  <= ST_STOP;
               updown_q <= updown_q;
            end
         endcase
      end
   end

   // Outputs are decoded purely from registered state so they cannot glitch on button activity.
   assign bus.o_run    = (state_q == ST_RUN);
   assign bus.o_clear  = (state_q == ST_CLEAR);
   assign bus.o_updown = updown_q;
   assign bus.o_state  = state_q;

endmodule
